// File: rtl/gsps_pkg.sv
// gsps_pkg: shared levels, mode encodings and Gray mapper for the GSPS symbol source and filter bench
package gsps_pkg;

    localparam int GSPS_W     = 18;
    localparam int LVL_HI_DEF = 98303;
    localparam int LVL_LO_DEF = 32768;

    typedef enum logic [1:0] {
        MODE_PRBS  = 2'd0,
        MODE_IMP   = 2'd1,
        MODE_CONST = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_t;

    function automatic logic [GSPS_W-1:0] gray_map(input logic [1:0] b, input int hi, input int lo);
        logic [GSPS_W-1:0] h;
        logic [GSPS_W-1:0] l;
        h = GSPS_W'(hi);
        l = GSPS_W'(lo);
        return b[1] ? (b[0] ? l : h) : (b[0] ? -l : -h);
    endfunction

endpackage

// File: rtl/gsps_prbs_lfsr.sv
// gsps_prbs_lfsr: Fibonacci LFSR (x^W+x^(W-1)+1) stepping twice per enable, with zero-state reload and wrap flag
module gsps_prbs_lfsr #(
    parameter int           W    = 15,
    parameter logic [W-1:0] SEED = {W{1'b1}}
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_step,
    output logic [1:0] o_bits,
    output logic       o_wrap
);

    logic [W-1:0] r_state;
    logic [W-1:0] w_s1;
    logic [W-1:0] w_s2;
    logic [W-1:0] w_next;

    assign w_s1   = {r_state[W-2:0], r_state[W-1] ^ r_state[W-2]};
    assign w_s2   = {w_s1[W-2:0], w_s1[W-1] ^ w_s1[W-2]};
    assign w_next = (r_state == '0) ? SEED : w_s2;
    assign o_bits = {r_state[W-1], w_s1[W-1]};
    assign o_wrap = (w_next == SEED);

    // advance two bits per enabled cycle; a stuck all-zero state recovers to SEED
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= SEED;
        else if (i_step) r_state <= w_next;
    end

endmodule

// File: rtl/gsps_sym_src.sv
// gsps_sym_src: clock-enable divider, PRBS/impulse/constant 4-ASK symbol source for the GSPS filter
module gsps_sym_src
    import gsps_pkg::*;
#(
    parameter int                WIDTH      = GSPS_W,
    parameter int                SAM_DIV    = 4,
    parameter int                SPS        = 4,
    parameter int                LFSR_W     = 15,
    parameter logic [LFSR_W-1:0] SEED       = 15'h7FFF,
    parameter int                LVL_HI     = LVL_HI_DEF,
    parameter int                LVL_LO     = LVL_LO_DEF,
    parameter int                IMP_PERIOD = 128,
    parameter int                ZERO_STUFF = 1
) (
    input  logic             i_sys_clk,
    input  logic             i_reset,
    input  logic [1:0]       i_mode,
    output logic             o_sam_clk_en,
    output logic             o_sym_clk_en,
    output logic [WIDTH-1:0] o_x_out,
    output logic [1:0]       o_sym_bits,
    output logic             o_lfsr_wrap
);

    localparam int CW = $clog2(SAM_DIV + 1);
    localparam int SW = $clog2(SPS + 1);
    localparam int IW = $clog2(IMP_PERIOD + 1);

    logic [CW-1:0]    r_cyc;
    logic [SW-1:0]    r_sam;
    logic [IW-1:0]    r_imp;
    mode_t            r_mode;
    logic             r_sam_en;
    logic             r_sym_en;
    logic [WIDTH-1:0] r_x;
    logic [1:0]       r_bits;
    logic             r_wrap;

    logic             w_sam;
    logic             w_sym;
    mode_t            w_mode;
    logic             w_step;
    logic [IW-1:0]    w_icnt;
    logic [1:0]       w_bits;
    logic             w_wrap;
    logic [WIDTH-1:0] w_x;

    assign w_sam  = (r_cyc == CW'(SAM_DIV - 1));
    assign w_sym  = w_sam && (r_sam == '0);
    assign w_mode = (i_mode == MODE_RSVD) ? MODE_PRBS : mode_t'(i_mode);
    assign w_step = w_sym && (w_mode == MODE_PRBS);
    assign w_icnt = (r_mode == MODE_IMP) ? r_imp : '0;
    assign w_x    = (w_mode == MODE_PRBS) ? WIDTH'(gray_map(w_bits, LVL_HI, LVL_LO)) :
                    (w_mode == MODE_IMP)  ? ((w_icnt == '0) ? WIDTH'(LVL_HI) : '0) :
                                            WIDTH'(LVL_LO);

    gsps_prbs_lfsr #(
        .W    (LFSR_W),
        .SEED (SEED)
    ) u_lfsr (
        .i_clk   (i_sys_clk),
        .i_rst_n (i_reset),
        .i_step  (w_step),
        .o_bits  (w_bits),
        .o_wrap  (w_wrap)
    );

    // sample and symbol counters; the symbol boundary is the sample boundary with sam_cnt at 0
    always_ff @(posedge i_sys_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cyc <= '0;
            r_sam <= '0;
        end else begin
            r_cyc <= w_sam ? '0 : r_cyc + 1'b1;
            if (w_sam) r_sam <= (r_sam == SW'(SPS - 1)) ? '0 : r_sam + 1'b1;
        end
    end

    // mode is latched only at symbol boundaries; the impulse counter restarts on entry to impulse mode
    always_ff @(posedge i_sys_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_mode <= MODE_PRBS;
            r_imp  <= '0;
        end else if (w_sym) begin
            r_mode <= w_mode;
            if (w_mode == MODE_IMP) r_imp <= (w_icnt == IW'(IMP_PERIOD - 1)) ? '0 : w_icnt + 1'b1;
        end
    end

    // registered outputs; symbol data changes with sym_clk_en, zero-stuffed on other sample boundaries
    always_ff @(posedge i_sys_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_sam_en <= 1'b0;
            r_sym_en <= 1'b0;
            r_x      <= '0;
            r_bits   <= '0;
            r_wrap   <= 1'b0;
        end else begin
            r_sam_en <= w_sam;
            r_sym_en <= w_sym;
            r_wrap   <= w_step && w_wrap;
            if (w_sym) begin
                r_x    <= w_x;
                r_bits <= (w_mode == MODE_PRBS) ? w_bits : '0;
            end else if (w_sam && ZERO_STUFF != 0) begin
                r_x    <= '0;
            end
        end
    end

    assign o_sam_clk_en = r_sam_en;
    assign o_sym_clk_en = r_sym_en;
    assign o_x_out      = r_x;
    assign o_sym_bits   = r_bits;
    assign o_lfsr_wrap  = r_wrap;

endmodule
